// File: rtl/servo_pkg.sv
// Shared constants and saturating helpers for the multi-channel servo PWM block.
// The helpers use 32-bit arithmetic, so a step can never wrap past a limit.
package servo_pkg;

  localparam int unsigned PERIOD    = 240000;
  localparam int unsigned POS_INIT  = 18000;
  localparam int unsigned POS_MIN   = 6000;
  localparam int unsigned POS_MAX   = 30000;
  localparam int unsigned STEP      = 1200;
  localparam int unsigned RAMP_STEP = 600;
  localparam int unsigned DEB_BITS  = 17;

  typedef logic [31:0] wide_t;

  function automatic wide_t clamp_add(wide_t pos, wide_t step, wide_t pos_max);
    wide_t sum;
    sum = pos + step;
    return (sum > pos_max) ? pos_max : sum;
  endfunction

  // Compare before subtracting so an unsigned underflow is impossible.
  function automatic wide_t clamp_sub(wide_t pos, wide_t step, wide_t pos_min);
    return (pos < pos_min + step) ? pos_min : pos - step;
  endfunction

endpackage

// File: rtl/btn_debounce_pulse.sv
// Raw button -> 2-flop synchroniser -> down-counter debouncer -> 1-cycle press pulse.
// The level must hold for 2^(DEB_BITS-1)+1 cycles before it is accepted.
module btn_debounce_pulse #(
  parameter int unsigned DEB_BITS = servo_pkg::DEB_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic pulse
);

  localparam logic [DEB_BITS-1:0] LOAD = {1'b1, {(DEB_BITS-1){1'b0}}};

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                level_q, level_d;
  logic                level_dly_q, level_dly_d;
  logic                pulse_q, pulse_d;
  logic [DEB_BITS-1:0] cnt_q, cnt_d;

  // Any sample that agrees with the accepted level reloads the timer.
  always_comb begin
    sync1_d     = btn_in;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = LOAD;
    if (sync2_q != level_q) begin
      if (cnt_q == '0) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q - DEB_BITS'(1);
      end
    end
    level_dly_d = level_q;
    pulse_d     = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
      cnt_q       <= LOAD;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
      cnt_q       <= cnt_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM generator with SEL/INC/DEC button control.
// Define SERVO_RAMP_EN to slew each active width toward its target by RAMP_STEP per frame.
module servo_pwm_multi #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CW        = 2,
  parameter int unsigned PW        = 18,
  parameter int unsigned PERIOD    = servo_pkg::PERIOD,
  parameter int unsigned POS_INIT  = servo_pkg::POS_INIT,
  parameter int unsigned POS_MIN   = servo_pkg::POS_MIN,
  parameter int unsigned POS_MAX   = servo_pkg::POS_MAX,
  parameter int unsigned STEP      = servo_pkg::STEP,
  parameter int unsigned DEB_BITS  = servo_pkg::DEB_BITS,
  parameter int unsigned RAMP_STEP = servo_pkg::RAMP_STEP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_sel,
  input  logic            btn_inc,
  input  logic            btn_dec,
  output logic [N_CH-1:0] servo,
  output logic [CW-1:0]   sel_ch,
  output logic            frame
);

  import servo_pkg::*;

`ifdef SERVO_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  // Without ramping the slew limit is POS_MAX, which exceeds any possible
  // target/active gap, so the active width jumps to the target in one frame.
  localparam wide_t SLEW = RAMP_EN ? wide_t'(RAMP_STEP) : wide_t'(POS_MAX);

  logic            sel_p, inc_p, dec_p, step_en;
  logic [PW-1:0]   counter_q, counter_d;
  logic [CW-1:0]   sel_ch_q, sel_ch_d;
  logic [PW-1:0]   target_q [N_CH];
  logic [PW-1:0]   target_d [N_CH];
  logic [PW-1:0]   active_q [N_CH];
  logic [PW-1:0]   active_d [N_CH];
  logic [N_CH-1:0] servo_q, servo_d;

  btn_debounce_pulse #(.DEB_BITS(DEB_BITS)) u_deb_sel (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_sel), .pulse(sel_p));
  btn_debounce_pulse #(.DEB_BITS(DEB_BITS)) u_deb_inc (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_inc), .pulse(inc_p));
  btn_debounce_pulse #(.DEB_BITS(DEB_BITS)) u_deb_dec (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_dec), .pulse(dec_p));

  assign frame   = (counter_q == PW'(PERIOD - 1));
  assign step_en = inc_p ^ dec_p;

  always_comb begin
    counter_d = frame ? '0 : counter_q + PW'(1);
    sel_ch_d  = sel_ch_q;
    if (sel_p) begin
      sel_ch_d = (sel_ch_q == CW'(N_CH - 1)) ? '0 : sel_ch_q + CW'(1);
    end
    for (int i = 0; i < N_CH; i++) begin
      target_d[i] = target_q[i];
      active_d[i] = active_q[i];
      servo_d[i]  = (counter_q < active_q[i]);
      // Steps use the pre-update sel_ch_q, so a coincident SEL hits the old channel.
      if (step_en && (sel_ch_q == CW'(i))) begin
        target_d[i] = inc_p
          ? PW'(clamp_add(wide_t'(target_q[i]), wide_t'(STEP), wide_t'(POS_MAX)))
          : PW'(clamp_sub(wide_t'(target_q[i]), wide_t'(STEP), wide_t'(POS_MIN)));
      end
      if (frame) begin
        active_d[i] = (active_q[i] <= target_q[i])
          ? PW'(clamp_add(wide_t'(active_q[i]), SLEW, wide_t'(target_q[i])))
          : PW'(clamp_sub(wide_t'(active_q[i]), SLEW, wide_t'(target_q[i])));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter_q <= '0;
      sel_ch_q  <= '0;
      servo_q   <= '0;
      for (int i = 0; i < N_CH; i++) begin
        target_q[i] <= PW'(POS_INIT);
        active_q[i] <= PW'(POS_INIT);
      end
    end else begin
      counter_q <= counter_d;
      sel_ch_q  <= sel_ch_d;
      servo_q   <= servo_d;
      for (int i = 0; i < N_CH; i++) begin
        target_q[i] <= target_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign servo  = servo_q;
  assign sel_ch = sel_ch_q;

endmodule
